// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache with a simple request/ready refill port.
// Optional DCACHE_STATS_EN adds free-running hit/miss/writeback counters.
module dcache_direct_mapped #(
  parameter int unsigned CACHE_WORD_SIZE = 32,
  parameter int unsigned NUM_LINES       = 16,
  parameter int unsigned ADDR_SIZE       = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [ADDR_SIZE-1:0]       addr_i,
  input  logic [CACHE_WORD_SIZE-1:0] wr_data_i,
  input  logic [1:0]                 wr_size_i,
  input  logic                       write_i,
  input  logic                       access_i,
  output logic [CACHE_WORD_SIZE-1:0] rd_data_o,
  output logic                       hit_o,
  output logic [ADDR_SIZE-1:0]       mem_addr_o,
  output logic [CACHE_WORD_SIZE-1:0] mem_wr_data_o,
  output logic                       mem_write_o,
  output logic                       mem_req_o,
  input  logic [CACHE_WORD_SIZE-1:0] mem_rd_data_i,
  input  logic                       mem_ready_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                hit_count_o,
  output logic [31:0]                miss_count_o,
  output logic [31:0]                writeback_count_o
`endif
);

  localparam logic [1:0] CACHE_ACCESS_SIZE_BYTE = 2'd0;
  localparam logic [1:0] CACHE_ACCESS_SIZE_HALF = 2'd1;
  localparam logic [1:0] CACHE_ACCESS_SIZE_WORD = 2'd2;

  localparam int unsigned NumBytes    = CACHE_WORD_SIZE / 8;
  localparam int unsigned OFFSET_BITS = $clog2(NumBytes);
  localparam int unsigned INDEX_BITS  = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS    = ADDR_SIZE - INDEX_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {StCompare, StWriteback, StAllocate} state_e;

  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_off;

  assign req_tag = addr_i[ADDR_SIZE-1 -: TAG_BITS];
  assign req_idx = addr_i[OFFSET_BITS +: INDEX_BITS];
  assign req_off = addr_i[OFFSET_BITS-1:0];

  state_e                    state_q, state_d;
  logic [NUM_LINES-1:0]      valid_q, valid_d;
  logic [NUM_LINES-1:0]      dirty_q, dirty_d;
  logic [TAG_BITS-1:0]       tag_q  [NUM_LINES];
  logic [CACHE_WORD_SIZE-1:0] data_q [NUM_LINES];

  logic [INDEX_BITS-1:0]      miss_idx_q, miss_idx_d;
  logic [TAG_BITS-1:0]        miss_tag_q, miss_tag_d;
  logic                       mem_req_q, mem_req_d;
  logic                       mem_write_q, mem_write_d;
  logic [ADDR_SIZE-1:0]       mem_addr_q, mem_addr_d;
  logic [CACHE_WORD_SIZE-1:0] mem_wr_data_q, mem_wr_data_d;

  logic                       data_we, tag_we;
  logic [INDEX_BITS-1:0]      line_idx;
  logic [TAG_BITS-1:0]        line_tag;
  logic [CACHE_WORD_SIZE-1:0] line_data;
  logic [CACHE_WORD_SIZE-1:0] store_line;
  logic                       miss_start, wb_done;
  int                         n_bytes;

  assign hit_o     = access_i && (state_q == StCompare) && valid_q[req_idx] &&
                     (tag_q[req_idx] == req_tag);
  assign rd_data_o = data_q[req_idx];

  assign mem_req_o     = mem_req_q;
  assign mem_write_o   = mem_write_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_data_o = mem_wr_data_q;

  // Byte-lane merge of store data into the current line; lanes past the line end are dropped.
  always_comb begin
    case (wr_size_i)
      CACHE_ACCESS_SIZE_BYTE: n_bytes = 1;
      CACHE_ACCESS_SIZE_HALF: n_bytes = 2;
      CACHE_ACCESS_SIZE_WORD: n_bytes = 4;
      default:                n_bytes = 4;
    endcase
    store_line = data_q[req_idx];
    for (int b = 0; b < int'(NumBytes); b++) begin
      if (b >= int'(req_off) && b < int'(req_off) + n_bytes) begin
        store_line[b*8 +: 8] = wr_data_i[(b - int'(req_off))*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    miss_idx_d    = miss_idx_q;
    miss_tag_d    = miss_tag_q;
    mem_req_d     = mem_req_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    data_we       = 1'b0;
    tag_we        = 1'b0;
    line_idx      = req_idx;
    line_tag      = req_tag;
    line_data     = store_line;
    miss_start    = 1'b0;
    wb_done       = 1'b0;

    case (state_q)
      StCompare: begin
        if (hit_o) begin
          if (write_i) begin
            data_we          = 1'b1;
            dirty_d[req_idx] = 1'b1;
          end
        end else if (access_i) begin
          miss_start = 1'b1;
          miss_idx_d = req_idx;
          miss_tag_d = req_tag;
          mem_req_d  = 1'b1;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d       = StWriteback;
            mem_write_d   = 1'b1;
            mem_addr_d    = {tag_q[req_idx], req_idx, {OFFSET_BITS{1'b0}}};
            mem_wr_data_d = data_q[req_idx];
          end else begin
            state_d     = StAllocate;
            mem_write_d = 1'b0;
            mem_addr_d  = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
          end
        end
      end
      StWriteback: begin
        if (mem_ready_i) begin
          wb_done             = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
          state_d             = StAllocate;
          mem_write_d         = 1'b0;
          mem_addr_d          = {miss_tag_q, miss_idx_q, {OFFSET_BITS{1'b0}}};
        end
      end
      StAllocate: begin
        if (mem_ready_i) begin
          data_we             = 1'b1;
          tag_we              = 1'b1;
          line_idx            = miss_idx_q;
          line_tag            = miss_tag_q;
          line_data           = mem_rd_data_i;
          valid_d[miss_idx_q] = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
          mem_req_d           = 1'b0;
          state_d             = StCompare;
        end
      end
      default: state_d = StCompare;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= StCompare;
      valid_q       <= '0;
      dirty_q       <= '0;
      miss_idx_q    <= '0;
      miss_tag_q    <= '0;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      dirty_q       <= dirty_d;
      miss_idx_q    <= miss_idx_d;
      miss_tag_q    <= miss_tag_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  // Tag and data arrays carry no reset; valid_q gates their use.
  always_ff @(posedge clk_i) begin
    if (data_we) data_q[line_idx] <= line_data;
    if (tag_we)  tag_q[line_idx]  <= line_tag;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + 32'(hit_o);
    miss_cnt_d = miss_cnt_q + 32'(miss_start);
    wb_cnt_d   = wb_cnt_q + 32'(wb_done);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_count_o       = hit_cnt_q;
  assign miss_count_o      = miss_cnt_q;
  assign writeback_count_o = wb_cnt_q;
`endif

endmodule
